// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Takes complete 11-bit UART frames from an upstream bit sampler, checks the
// start/stop framing and (optionally) even parity, and queues the data bytes
// of good frames in a 4-entry FIFO for a downstream consumer. Bad frames are
// dropped and counted.
//
// Pipeline: PACKET_VALID in cycle n loads the capture register. In cycle n+1
// the check stage evaluates the captured frame. A good byte is written into
// the FIFO on the edge that ends cycle n+1, so DATA_VALID rises in cycle n+2.
// There is no path from PACKET_IN to DATA_OUT that bypasses the FIFO.
//
// Build option:
//   DEFRAMER_PARITY_EN  defined   -> parity bit checked (even parity over
//                                    d0..d7 plus the parity bit)
//                       undefined -> parity bit ignored, PARITY_ERR_CNT = 0
//
// Ports:
//   UART_CLK        in   1  clock, everything on the rising edge
//   RESET_L         in   1  synchronous active-low reset
//   PACKET_IN       in  11  [10]=start, [9:2]=d0..d7 (d0 at [9]),
//                           [1]=parity, [0]=stop
//   PACKET_VALID    in   1  one-cycle strobe, PACKET_IN is complete
//   DATA_READY      in   1  downstream accepts DATA_OUT this cycle
//   CLR_ERR         in   1  clears both error counters and OVERFLOW
//   DATA_OUT        out  8  byte at the head of the FIFO (0x00 when empty)
//   DATA_VALID      out  1  FIFO not empty
//   FRAME_ERR_CNT   out  8  saturating count of bad start/stop frames
//   PARITY_ERR_CNT  out  8  saturating count of parity failures
//   OVERFLOW        out  1  sticky: a good byte was dropped, FIFO full
// -----------------------------------------------------------------------------
module uart_rx_deframer (
  input  logic        UART_CLK,
  input  logic        RESET_L,
  input  logic [10:0] PACKET_IN,
  input  logic        PACKET_VALID,
  input  logic        DATA_READY,
  input  logic        CLR_ERR,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_VALID,
  output logic [7:0]  FRAME_ERR_CNT,
  output logic [7:0]  PARITY_ERR_CNT,
  output logic        OVERFLOW
);

  localparam int         DEPTH    = 4;
  localparam logic [2:0] FULL_CNT = 3'd4;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  // ---------------------------------------------------------------------------
  // Capture stage
  // ---------------------------------------------------------------------------
  logic        cap_valid_q, cap_valid_d;
  logic [10:0] cap_frame_q, cap_frame_d;

  always_comb begin
    cap_valid_d = PACKET_VALID;
    cap_frame_d = cap_frame_q;
    if (PACKET_VALID) begin
      cap_frame_d = PACKET_IN;
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (!RESET_L) begin
      cap_valid_q <= 1'b0;
      cap_frame_q <= 11'h000;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_frame_q <= cap_frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Check stage (combinational on the capture register)
  // ---------------------------------------------------------------------------
  logic       chk_start;
  logic       chk_stop;
  logic       chk_parity;
  logic [7:0] chk_byte;
  logic       frame_err;
  logic       parity_err;
  logic       byte_good;

  assign chk_start  = cap_frame_q[10];
  assign chk_parity = cap_frame_q[1];
  assign chk_stop   = cap_frame_q[0];

  // d0 arrives first and sits at the top of the data field, so the byte is
  // the data field bit-reversed.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_map
      assign chk_byte[gi] = cap_frame_q[9-gi];
    end
  endgenerate

  assign frame_err = cap_valid_q & (chk_start | ~chk_stop);

`ifdef DEFRAMER_PARITY_EN
  // A framing error wins, so a frame is never counted twice.
  assign parity_err = cap_valid_q & ~frame_err & (chk_parity != (^chk_byte));
`else
  logic parity_unused;
  assign parity_err    = 1'b0;
  assign parity_unused = chk_parity;
`endif

  assign byte_good = cap_valid_q & ~frame_err & ~parity_err;

  // ---------------------------------------------------------------------------
  // 4-entry FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       drop;

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = ~fifo_empty & DATA_READY;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push       = byte_good & (~fifo_full | pop);
  assign drop       = byte_good & fifo_full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = chk_byte;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge UART_CLK) begin
    if (!RESET_L) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry only changes on a pop, so DATA_OUT holds while stalled.
  assign DATA_VALID = ~fifo_empty;
  assign DATA_OUT   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Error counters and overflow flag; CLR_ERR beats a same-cycle event
  // ---------------------------------------------------------------------------
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    if (CLR_ERR) begin
      frame_cnt_d = 8'h00;
      ovf_d       = 1'b0;
    end else begin
      if (frame_err && (frame_cnt_q != CNT_MAX)) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (!RESET_L) begin
      frame_cnt_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign FRAME_ERR_CNT = frame_cnt_q;
  assign OVERFLOW      = ovf_q;

`ifdef DEFRAMER_PARITY_EN
  logic [7:0] parity_cnt_q, parity_cnt_d;

  always_comb begin
    parity_cnt_d = parity_cnt_q;
    if (CLR_ERR) begin
      parity_cnt_d = 8'h00;
    end else if (parity_err && (parity_cnt_q != CNT_MAX)) begin
      parity_cnt_d = parity_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (!RESET_L) begin
      parity_cnt_q <= 8'h00;
    end else begin
      parity_cnt_q <= parity_cnt_d;
    end
  end

  assign PARITY_ERR_CNT = parity_cnt_q;
`else
  assign PARITY_ERR_CNT = 8'h00;
`endif

endmodule
